seq_double_dabble: RTL
======================

// Module: seq_double_dabble
// PURPOSE
//   Multi-cycle, parametrised binary-to-BCD converter using the shift/add-3 (double dabble) algorithm.
//   Performs one bit iteration per clock, so logic depth does not grow with BIN_W.
//   Sits between score/counter registers and the VGA digit renderer.
//   Uses a start/busy/done handshake and holds its result until the next conversion completes.
// PARAMETERS
//   BIN_W   8   width of the binary input
//   DIGITS  3   number of BCD output digits. Requires 10^DIGITS > 2^BIN_W-1; otherwise the upper digits are truncated.
// PORTS
//   clk      in   1            system clock, rising edge
//   rst      in   1            asynchronous, active-high reset
//   start    in   1            request a conversion of num_in; sampled on clk
//   num_in   in   BIN_W        binary value; captured only on an accepted start
//   busy     out  1            conversion in progress
//   done     out  1            one-cycle pulse: bcd_out has just been updated
//   bcd_out  out  4*DIGITS     result; digit k is [4k+3:4k], digit 0 = ones
//   blank    out  DIGITS       leading-zero mask; present only with SEQ_DD_BLANK_EN
// BEHAVIOUR
//   Reset (asynchronous, rst=1): state=IDLE, busy=0, done=0, bcd_out=0, blank=0, internal shift/work regs=0.
//   States:
//     IDLE -> CONV on start=1. On that edge: latch num_in into the shift reg, clear the BCD work reg,
//       set bit counter=BIN_W-1, busy=1.
//     CONV: on each edge, for every work digit that is >=5, add 3 (4-bit, no carry out of the digit).
//       Then shift {work, shreg} left by 1, with the MSB of shreg entering work[0]. Decrement the counter.
//     CONV -> IDLE on the edge that performs the iteration with counter==0. On that same edge:
//       bcd_out <= final work value, done=1, busy=0.
//   Latency: the accept edge is edge 0; done and bcd_out are valid after edge BIN_W, i.e. exactly BIN_W cycles.
//     Throughput is one conversion per BIN_W cycles.
//   done is high for exactly one cycle and is cleared on the next edge unconditionally.
//   start while busy=1: ignored; num_in is not re-sampled and no queueing occurs.
//   start during the done cycle: accepted, because state is already IDLE. The next conversion begins
//     with no gap and bcd_out keeps the completed value.
//   bcd_out is never cleared by start; it changes only on completion or reset.
//   num_in may change freely after the accept edge.
//   Reset mid-conversion: abort immediately to the reset values. No done pulse is produced.
//   Work reg width is 4*DIGITS. Bits shifted out of the top digit are discarded (truncation case only).
//   No combinational path from inputs to outputs.
// CONFIGURATION
//   SEQ_DD_BLANK_EN defined:
//     Adds the blank output, registered with bcd_out on the completion edge.
//     blank[k]=1 when digit k and every digit above it are zero, for k>=1.
//     blank[0] is always 0, so the ones digit is always shown.
//     blank is reset to 0.
//   SEQ_DD_BLANK_EN undefined:
//     The blank port and its logic are absent. All other behaviour is identical.
// TESTING
//   1. Defaults: reset, then start with num_in=8'd255 -> done after 8 cycles, bcd_out=12'h255,
//      busy high for cycles 1..8.
//   2. Values 0, 9, 10, 99, 100, 128 -> bcd_out 12'h000, 009, 010, 099, 100, 128.
//      Also sweep all 256 inputs against a reference model.
//   3. start=1 held through a conversion of 8'd42 while num_in changes to 8'd7 ->
//      result is 12'h042; a second conversion of 7 starts on the done cycle and
//      finishes 8 cycles later with 12'h007.
//   4. Assert rst at cycle 4 of a conversion of 8'd200 -> busy=0, done=0, bcd_out=0 at once;
//      no done pulse follows; a new start of 8'd200 gives 12'h200.
//   5. BIN_W=16, DIGITS=5: num_in=16'd65535 -> bcd_out=20'h65535 after 16 cycles;
//      num_in=16'd1000 -> 20'h01000.
//   6. SEQ_DD_BLANK_EN defined: 7 -> blank=3'b110; 0 -> 3'b110; 50 -> 3'b100; 255 -> 3'b000.

Source files
------------

// File: rtl/seq_double_dabble.sv
// Sequential binary-to-BCD converter (shift / add-3), one bit per clock, start/busy/done handshake.
// Define SEQ_DD_BLANK_EN to add the registered leading-zero blank mask output.
module seq_double_dabble #(
  parameter int BIN_W  = 8,
  parameter int DIGITS = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [BIN_W-1:0]    num_in,
  output logic                busy,
  output logic                done,
  output logic [4*DIGITS-1:0] bcd_out
`ifdef SEQ_DD_BLANK_EN
  ,
  output logic [DIGITS-1:0]   blank
`endif
);

  localparam int WW = 4 * DIGITS;
  localparam int CW = (BIN_W > 1) ? $clog2(BIN_W) : 1;

  typedef enum logic {IDLE, CONV} state_t;

  state_t          state_q;
  logic [BIN_W-1:0] shreg_q, shreg_d;
  logic [WW-1:0]    work_q, work_d, work_adj;
  logic [CW-1:0]    cnt_q;

  // One iteration: add 3 to every digit >= 5, then shift the next binary bit in.
  always_comb begin
    work_adj = work_q;
    for (int k = 0; k < DIGITS; k++) begin
      if (work_q[4*k +: 4] >= 4'd5) begin
        work_adj[4*k +: 4] = work_q[4*k +: 4] + 4'd3;
      end
    end
    work_d  = {work_adj[WW-2:0], shreg_q[BIN_W-1]};
    shreg_d = shreg_q << 1;
  end

`ifdef SEQ_DD_BLANK_EN
  logic [DIGITS-1:0] blank_d;
  logic              upper_zero;

  // A digit is blanked only if it and everything above it are zero; the ones digit always shows.
  always_comb begin
    upper_zero = 1'b1;
    blank_d    = '0;
    for (int k = DIGITS - 1; k >= 1; k--) begin
      upper_zero = upper_zero & (work_d[4*k +: 4] == 4'd0);
      blank_d[k] = upper_zero;
    end
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      bcd_out <= '0;
      shreg_q <= '0;
      work_q  <= '0;
      cnt_q   <= '0;
`ifdef SEQ_DD_BLANK_EN
      blank   <= '0;
`endif
    end else begin
      done <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q <= CONV;
            busy    <= 1'b1;
            shreg_q <= num_in;
            work_q  <= '0;
            cnt_q   <= CW'(BIN_W - 1);
          end
        end
        CONV: begin
          shreg_q <= shreg_d;
          work_q  <= work_d;
          cnt_q   <= cnt_q - CW'(1);
          if (cnt_q == '0) begin
            state_q <= IDLE;
            busy    <= 1'b0;
            done    <= 1'b1;
            bcd_out <= work_d;
`ifdef SEQ_DD_BLANK_EN
            blank   <= blank_d;
`endif
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
